// File: rtl/reg_wb_pkg.sv
// Shared definitions for the write-back arbiter: register-file geometry,
// requester index type and the two-way round-robin pick function.
package reg_wb_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_ID_W = 5;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_idx_t;

  // The requester that did not win last time takes a conflict.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input req_idx_t last);
    logic [1:0] gnt;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == REQ_LSU) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    return gnt;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, last-grant pointer moves
// only when the grant is actually consumed (advance).
module rr_arb2
  import reg_wb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  req_idx_t r_last;

  assign gnt = rr_pick(req, r_last);

  // Last-grant pointer; reset to the load unit so the ALU wins the first conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= REQ_LSU;
    end else if (advance) begin
      r_last <= gnt[1] ? REQ_LSU : REQ_ALU;
    end else begin
      r_last <= r_last;
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file write-back arbiter with optional pending-write scoreboard.
// Optional feature macro: REG_WB_SCOREBOARD_EN.
module reg_wb_arbiter
  import reg_wb_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  input  logic [REG_ID_W-1:0] req0_rd,
  input  logic [DWIDTH-1:0]   req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [REG_ID_W-1:0] req1_rd,
  input  logic [DWIDTH-1:0]   req1_data,
  output logic                req1_ready,
  output logic                we,
  output logic [REG_ID_W-1:0] rdst_id,
  output logic [DWIDTH-1:0]   rdst,
  input  logic                alloc_valid,
  input  logic [REG_ID_W-1:0] alloc_rd,
  input  logic [REG_ID_W-1:0] rs1_id,
  input  logic [REG_ID_W-1:0] rs2_id,
  output logic                rs1_busy,
  output logic                rs2_busy
);

  logic [1:0]          w_gnt;
  logic                w_hs;
  logic                r_we;
  logic [REG_ID_W-1:0] r_rdst_id;
  logic [DWIDTH-1:0]   r_rdst;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1_valid, req0_valid}),
    .advance (w_hs),
    .gnt     (w_gnt)
  );

  // Grant is already qualified by valid inside the arbiter.
  assign req0_ready = w_gnt[0] & ~rst;
  assign req1_ready = w_gnt[1] & ~rst;
  assign w_hs       = req0_ready | req1_ready;

  // Write-back register: capture the accepted request, r0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we      <= 1'b0;
      r_rdst_id <= {REG_ID_W{1'b0}};
      r_rdst    <= {DWIDTH{1'b0}};
    end else if (req0_ready) begin
      r_we      <= (req0_rd != {REG_ID_W{1'b0}});
      r_rdst_id <= req0_rd;
      r_rdst    <= req0_data;
    end else if (req1_ready) begin
      r_we      <= (req1_rd != {REG_ID_W{1'b0}});
      r_rdst_id <= req1_rd;
      r_rdst    <= req1_data;
    end else begin
      r_we      <= 1'b0;
      r_rdst_id <= r_rdst_id;
      r_rdst    <= r_rdst;
    end
  end

  assign we      = r_we;
  assign rdst_id = r_rdst_id;
  assign rdst    = r_rdst;

`ifdef REG_WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pending_nxt;

  // Clear on commit first so a same-edge allocation of that register wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (r_we) begin
      w_pending_nxt[r_rdst_id] = 1'b0;
    end else begin
      w_pending_nxt = r_pending;
    end
    if (alloc_valid && (alloc_rd != {REG_ID_W{1'b0}})) begin
      w_pending_nxt[alloc_rd] = 1'b1;
    end else begin
      w_pending_nxt[0] = 1'b0;
    end
    w_pending_nxt[0] = 1'b0;
  end

  // Pending-write bit per architectural register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= {NUM_REGS{1'b0}};
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  assign rs1_busy = r_pending[rs1_id];
  assign rs2_busy = r_pending[rs2_id];
`else
  logic w_unused_sb;

  assign w_unused_sb = ^{alloc_valid, alloc_rd, rs1_id, rs2_id};
  assign rs1_busy    = 1'b0;
  assign rs2_busy    = 1'b0;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed table-driven bench for reg_wb_arbiter plus hand-written
// sequences for scoreboard and mid-operation reset.
module tb_reg_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_rd, req1_rd;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        we;
  logic [4:0]  rdst_id;
  logic [31:0] rdst;
  logic        alloc_valid;
  logic [4:0]  alloc_rd, rs1_id, rs2_id;
  logic        rs1_busy, rs2_busy;

  int checks = 0;
  int errors = 0;

  reg_wb_arbiter #(.DWIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
    .we(we), .rdst_id(rdst_id), .rdst(rdst),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic [4:0]  rd0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  rd1;
    logic [31:0] d1;
    logic        er0;
    logic        er1;
    logic        ewe;
    logic        chk_hold;
    logic [4:0]  eid;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_rd = 5'd0; req0_data = 32'h0;
    req1_valid = 1'b0; req1_rd = 5'd0; req1_data = 32'h0;
    alloc_valid = 1'b0; alloc_rd = 5'd0;
  endtask

  initial begin
    // v0 rd0 d0 | v1 rd1 d1 | er0 er1 | ewe hold eid ed   (reset leaves pointer at req1)
    tbl[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  32'h0};
    tbl[1]  = '{1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22,   1'b1, 1'b0, 1'b1, 1'b1, 5'd3,  32'h11};
    tbl[2]  = '{1'b0, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22,   1'b0, 1'b1, 1'b1, 1'b1, 5'd4,  32'h22};
    tbl[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, 1'b1, 5'd4,  32'h22};
    tbl[4]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF};
    tbl[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 32'h1234, 1'b0, 1'b1, 1'b1, 1'b1, 5'd10, 32'h1234};
    tbl[6]  = '{1'b1, 5'd7,  32'hA,        1'b1, 5'd7,  32'hB,    1'b1, 1'b0, 1'b1, 1'b1, 5'd7,  32'hA};
    tbl[7]  = '{1'b0, 5'd7,  32'hA,        1'b1, 5'd7,  32'hB,    1'b0, 1'b1, 1'b1, 1'b1, 5'd7,  32'hB};
    tbl[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h55,   1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0};
    tbl[9]  = '{1'b1, 5'd0,  32'h66,       1'b1, 5'd12, 32'h77,   1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
    tbl[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'h77,   1'b0, 1'b1, 1'b1, 1'b1, 5'd12, 32'h77};
    tbl[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 32'h77};

    // Reset with both requesters pushing: ready must stay low.
    idle_inputs();
    rs1_id = 5'd0; rs2_id = 5'd0;
    rst = 1'b1;
    req0_valid = 1'b1; req0_rd = 5'd1; req0_data = 32'h1;
    req1_valid = 1'b1; req1_rd = 5'd2; req1_data = 32'h2;
    cyc();
    cyc();
    chk("rst_ready0", {63'd0, req0_ready}, 64'd0);
    chk("rst_ready1", {63'd0, req1_ready}, 64'd0);
    chk("rst_we", {63'd0, we}, 64'd0);
    chk("rst_rdst_id", {59'd0, rdst_id}, 64'd0);
    chk("rst_rdst", {32'd0, rdst}, 64'd0);
    rst = 1'b0;
    idle_inputs();

    for (int i = 0; i < 12; i++) begin
      req0_valid = tbl[i].v0; req0_rd = tbl[i].rd0; req0_data = tbl[i].d0;
      req1_valid = tbl[i].v1; req1_rd = tbl[i].rd1; req1_data = tbl[i].d1;
      #3;
      chk($sformatf("vec%0d_ready0", i), {63'd0, req0_ready}, {63'd0, tbl[i].er0});
      chk($sformatf("vec%0d_ready1", i), {63'd0, req1_ready}, {63'd0, tbl[i].er1});
      cyc();
      chk($sformatf("vec%0d_we", i), {63'd0, we}, {63'd0, tbl[i].ewe});
      if (tbl[i].chk_hold) begin
        chk($sformatf("vec%0d_rdst_id", i), {59'd0, rdst_id}, {59'd0, tbl[i].eid});
        chk($sformatf("vec%0d_rdst", i), {32'd0, rdst}, {32'd0, tbl[i].ed});
      end
    end
    idle_inputs();

`ifdef REG_WB_SCOREBOARD_EN
    alloc_valid = 1'b1; alloc_rd = 5'd9; rs1_id = 5'd9; rs2_id = 5'd9;
    #3;
    chk("sb_before_alloc", {63'd0, rs1_busy}, 64'd0);
    cyc();
    chk("sb_alloc_rs1", {63'd0, rs1_busy}, 64'd1);
    chk("sb_alloc_rs2", {63'd0, rs2_busy}, 64'd1);
    alloc_valid = 1'b0;
    req0_valid = 1'b1; req0_rd = 5'd9; req0_data = 32'h99;
    cyc();
    chk("sb_wb_we", {63'd0, we}, 64'd1);
    chk("sb_busy_at_we", {63'd0, rs1_busy}, 64'd1);
    req0_valid = 1'b0;
    cyc();
    chk("sb_cleared", {63'd0, rs1_busy}, 64'd0);
    alloc_valid = 1'b1; alloc_rd = 5'd9;
    cyc();
    alloc_valid = 1'b0;
    req0_valid = 1'b1; req0_rd = 5'd9; req0_data = 32'h9A;
    cyc();
    chk("sb_wb2_we", {63'd0, we}, 64'd1);
    req0_valid = 1'b0;
    alloc_valid = 1'b1; alloc_rd = 5'd9;
    cyc();
    chk("sb_set_wins", {63'd0, rs1_busy}, 64'd1);
    alloc_valid = 1'b1; alloc_rd = 5'd0; rs1_id = 5'd0;
    cyc();
    chk("sb_r0_never_busy", {63'd0, rs1_busy}, 64'd0);
    chk("sb_rs2_still_busy", {63'd0, rs2_busy}, 64'd1);
    alloc_valid = 1'b0;
`else
    alloc_valid = 1'b1; alloc_rd = 5'd9; rs1_id = 5'd9; rs2_id = 5'd9;
    cyc();
    cyc();
    chk("nosb_rs1_busy", {63'd0, rs1_busy}, 64'd0);
    chk("nosb_rs2_busy", {63'd0, rs2_busy}, 64'd0);
    alloc_valid = 1'b0;
`endif

    // Reset right after a req0 handshake: write dropped, pointer restored.
    rs1_id = 5'd6;
    req0_valid = 1'b1; req0_rd = 5'd6; req0_data = 32'h66;
    alloc_valid = 1'b1; alloc_rd = 5'd6;
    #3;
    chk("mid_ready0", {63'd0, req0_ready}, 64'd1);
    cyc();
    chk("mid_we", {63'd0, we}, 64'd1);
    chk("mid_rdst_id", {59'd0, rdst_id}, 64'd6);
    rst = 1'b1;
    req0_valid = 1'b0; alloc_valid = 1'b0;
    req1_valid = 1'b1; req1_rd = 5'd8; req1_data = 32'h88;
    #3;
    chk("mid_rst_ready1", {63'd0, req1_ready}, 64'd0);
    cyc();
    chk("mid_rst_we", {63'd0, we}, 64'd0);
    chk("mid_rst_rdst", {32'd0, rdst}, 64'd0);
    chk("mid_rst_busy", {63'd0, rs1_busy}, 64'd0);
    rst = 1'b0;
    req0_valid = 1'b1; req0_rd = 5'd1; req0_data = 32'h1;
    req1_valid = 1'b1; req1_rd = 5'd2; req1_data = 32'h2;
    #3;
    chk("post_rst_ready0", {63'd0, req0_ready}, 64'd1);
    chk("post_rst_ready1", {63'd0, req1_ready}, 64'd0);
    cyc();
    chk("post_rst_we", {63'd0, we}, 64'd1);
    chk("post_rst_rdst_id", {59'd0, rdst_id}, 64'd1);
    chk("post_rst_rdst", {32'd0, rdst}, 64'd1);
    idle_inputs();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
